snake_sprite_sequencer: RTL and testbench

Per-pixel controller that sequences the snake sprite ROM/palette datapath. It owns the current heading (up/down/left/right) and the animation frame. It places the sprite at a movable screen position and generates the ROM select and address for each pixel, plus a valid flag aligned to the ROM output. Heading changes are accepted through a valid/ready handshake and applied only at frame boundaries, so a sprite never tears mid-frame. It sits between the game logic and the four direction sprite ROMs and their palettes, in front of the colour-output register.

---
 rtl/snake_sprite_sequencer_if.sv | 33 +++
 rtl/snake_sprite_sequencer.sv | 148 ++++++++++++++
 tb/tb_snake_sprite_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_sprite_sequencer_if.sv
// Pixel/heading bus between the game logic and the snake sprite sequencer.
// Latency: none (wires only).
// Backpressure: dir_valid/dir_ready handshake on the heading request only.
// Ports: raster position and blank, sprite position, heading request
// handshake, and the ROM select/address, pixel-valid and frame status
// returned by the sequencer.
interface snake_sprite_sequencer_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [1:0]  dir_req;
  logic        dir_valid;
  logic        dir_ready;
  logic [1:0]  rom_sel;
  logic [10:0] rom_address;
  logic        pix_valid;
  logic        frame_tick;
  logic [1:0]  anim_frame;

  // Game logic / raster side
  modport master (
    output DrawX, DrawY, blank, sprite_x, sprite_y, dir_req, dir_valid,
    input  dir_ready, rom_sel, rom_address, pix_valid, frame_tick, anim_frame
  );

  // Sequencer side
  modport slave (
    input  DrawX, DrawY, blank, sprite_x, sprite_y, dir_req, dir_valid,
    output dir_ready, rom_sel, rom_address, pix_valid, frame_tick, anim_frame
  );
endinterface

// File: rtl/snake_sprite_sequencer.sv
// Snake sprite sequencer: owns heading and animation frame, generates ROM select/address per pixel.
// Latency: pixel in -> rom_address/rom_sel 1 cycle, -> pix_valid 2 cycles (aligned with ROM q).
// Backpressure: dir_ready low while a heading change is pending; it frees at the next frame tick.
// Ports: vga_clk (pixel clock), reset_n (async active-low), bus (slave side of
// snake_sprite_sequencer_if: raster/sprite inputs, heading handshake, ROM outputs).
module snake_sprite_sequencer #(
  parameter int SPR_W       = 21,
  parameter int SPR_H       = 45,
  parameter int V_ACTIVE    = 480,
  parameter int ANIM_DIV    = 8,
  parameter int ANIM_FRAMES = 2
) (
  input  logic                      vga_clk,
  input  logic                      reset_n,
  snake_sprite_sequencer_if.slave   bus
);

  localparam int          DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(ANIM_DIV - 1);
  localparam logic [1:0]  FR_MAX    = 2'(ANIM_FRAMES - 1);
  localparam logic [10:0] FRAME_SZ  = 11'(SPR_W * SPR_H);
  localparam logic [10:0] W11       = 11'(SPR_W);
  localparam logic [10:0] H11       = 11'(SPR_H);

  localparam logic [0:0]  ST_EMPTY   = 1'b0;
  localparam logic [0:0]  ST_PENDING = 1'b1;

  localparam logic [1:0]  DIR_DOWN   = 2'b01;

  logic [0:0]       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       heading_q, heading_d;
  logic             cond_prev_q, cond_prev_d;
  logic             frame_tick_q, frame_tick_d;
  logic [9:0]       px_q, px_d;
  logic [9:0]       py_q, py_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       anim_q, anim_d;
  logic [10:0]      addr_q, addr_d;
  logic [1:0]       sel_q, sel_d;
  logic             hit_q, hit_d;
  logic             pix_valid_q, pix_valid_d;

  logic             cond;
  logic             hit;
  logic [10:0]      x11, y11, px11, py11, lx, ly, base;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    heading_d    = heading_q;
    px_d         = px_q;
    py_d         = py_q;
    div_d        = div_q;
    anim_d       = anim_q;

    // Frame boundary: first cycle of the first non-visible line.
    cond         = (bus.DrawX == 10'd0) && (bus.DrawY == 10'(V_ACTIVE));
    cond_prev_d  = cond;
    frame_tick_d = cond && !cond_prev_q;

    // Requests are always judged against the applied heading, never the slot.
    case (state_q)
      ST_EMPTY: begin
        if (bus.dir_valid && (bus.dir_req != heading_q) &&
            (bus.dir_req != (heading_q ^ 2'b01))) begin
          slot_d  = bus.dir_req;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_tick_q) begin
          heading_d = slot_q;
          state_d   = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (frame_tick_q) begin
      px_d = bus.sprite_x;
      py_d = bus.sprite_y;
      if (div_q == DIV_MAX) begin
        div_d  = '0;
        anim_d = (anim_q == FR_MAX) ? 2'd0 : anim_q + 2'd1;
      end else begin
        div_d  = div_q + 1'b1;
      end
    end

    // 11-bit arithmetic so the right/bottom edges clip instead of wrapping.
    x11  = {1'b0, bus.DrawX};
    y11  = {1'b0, bus.DrawY};
    px11 = {1'b0, px_q};
    py11 = {1'b0, py_q};
    lx   = x11 - px11;
    ly   = y11 - py11;
    hit  = bus.blank && (x11 >= px11) && (x11 < px11 + W11) &&
           (y11 >= py11) && (y11 < py11 + H11);
    base = {9'd0, anim_q} * FRAME_SZ;

    addr_d      = hit ? (base + ly * W11 + lx) : 11'd0;
    sel_d       = heading_q;
    hit_d       = hit;
    // Second stage matches the ROM's one-cycle read latency.
    pix_valid_d = hit_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      slot_q       <= 2'd0;
      heading_q    <= DIR_DOWN;
      cond_prev_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      px_q         <= 10'd0;
      py_q         <= 10'd0;
      div_q        <= '0;
      anim_q       <= 2'd0;
      addr_q       <= 11'd0;
      sel_q        <= DIR_DOWN;
      hit_q        <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      heading_q    <= heading_d;
      cond_prev_q  <= cond_prev_d;
      frame_tick_q <= frame_tick_d;
      px_q         <= px_d;
      py_q         <= py_d;
      div_q        <= div_d;
      anim_q       <= anim_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      hit_q        <= hit_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

  assign bus.dir_ready   = (state_q == ST_EMPTY);
  assign bus.rom_sel     = sel_q;
  assign bus.rom_address = addr_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.frame_tick  = frame_tick_q;
  assign bus.anim_frame  = anim_q;

endmodule

// File: tb/tb_snake_sprite_sequencer.sv
module tb_snake_sprite_sequencer;
  localparam int VA = 480;

  localparam int K_ADDR = 0;
  localparam int K_PV   = 1;
  localparam int K_SEL  = 2;
  localparam int K_RDY  = 3;
  localparam int K_TICK = 4;
  localparam int K_ANIM = 5;

  typedef struct {
    int          due;
    int          kind;
    logic [10:0] val;
  } chk_t;

  logic vga_clk = 1'b0;
  logic reset_n;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   ntick = 0;
  chk_t sb[$];

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  snake_sprite_sequencer_if bus();

  snake_sprite_sequencer #(
    .SPR_W(21), .SPR_H(45), .V_ACTIVE(VA), .ANIM_DIV(8), .ANIM_FRAMES(2)
  ) dut (
    .vga_clk(vga_clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  function automatic string kname(int k);
    case (k)
      K_ADDR:  return "rom_address";
      K_PV:    return "pix_valid";
      K_SEL:   return "rom_sel";
      K_RDY:   return "dir_ready";
      K_TICK:  return "frame_tick";
      default: return "anim_frame";
    endcase
  endfunction

  function automatic logic [10:0] actual(int k);
    case (k)
      K_ADDR:  return bus.rom_address;
      K_PV:    return {10'd0, bus.pix_valid};
      K_SEL:   return {9'd0, bus.rom_sel};
      K_RDY:   return {10'd0, bus.dir_ready};
      K_TICK:  return {10'd0, bus.frame_tick};
      default: return {9'd0, bus.anim_frame};
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge vga_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [10:0] a;
        a = actual(sb[i].kind);
        tests++;
        if (a !== sb[i].val) begin
          fails++;
          $display("FAIL %s @cyc %0d: got %0d, expected %0d",
                   kname(sb[i].kind), cyc, a, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        tests++;
        fails++;
        $display("FAIL stale_%s @cyc %0d: due %0d never checked",
                 kname(sb[i].kind), cyc, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int due, input int k, input logic [10:0] v);
    sb.push_back('{due: due, kind: k, val: v});
  endtask

  task automatic chk(input int k, input logic [10:0] v);
    expect_at(cyc, k, v);
  endtask

  task automatic step(input logic [9:0] x, input logic [9:0] y, input logic b);
    @(posedge vga_clk);
    #1;
    bus.DrawX = x;
    bus.DrawY = y;
    bus.blank = b;
  endtask

  task automatic idle(input int n);
    repeat (n) step(10'd700, 10'd0, 1'b0);
  endtask

  // Drive one pixel; address/select due next cycle, pix_valid the one after.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic b,
                     input logic [10:0] ea, input logic epv, input logic [1:0] esel);
    step(x, y, b);
    expect_at(cyc + 1, K_ADDR, ea);
    expect_at(cyc + 1, K_SEL, {9'd0, esel});
    expect_at(cyc + 2, K_PV, {10'd0, epv});
  endtask

  task automatic chk_reset_vals();
    chk(K_ADDR, 11'd0);
    chk(K_PV, 11'd0);
    chk(K_SEL, 11'd1);
    chk(K_RDY, 11'd1);
    chk(K_TICK, 11'd0);
    chk(K_ANIM, 11'd0);
  endtask

  // Hold the boundary condition for 'hold' cycles; optionally raise a heading
  // request exactly in the cycle where frame_tick is high (hold must be 1).
  task automatic do_tick(input int hold, input bit req_en, input logic [1:0] req);
    int c0;
    step(10'd0, 10'(VA), 1'b0);
    c0 = cyc;
    expect_at(c0 + 1, K_TICK, 11'd1);
    for (int i = 2; i <= hold + 1; i++) expect_at(c0 + i, K_TICK, 11'd0);
    for (int i = 1; i < hold; i++) step(10'd0, 10'(VA), 1'b0);
    step(10'd1, 10'(VA), 1'b0);
    if (req_en) begin
      bus.dir_valid = 1'b1;
      bus.dir_req   = req;
      chk(K_RDY, 11'd1);
    end
    step(10'd2, 10'(VA), 1'b0);
    bus.dir_valid = 1'b0;
    if (req_en) chk(K_RDY, 11'd0);
    ntick++;
  endtask

  // Mid-frame request; ready must read 'rdy_after' in the following cycle.
  task automatic req(input logic [1:0] d, input logic rdy_after);
    step(10'd700, 10'd10, 1'b0);
    bus.dir_valid = 1'b1;
    bus.dir_req   = d;
    chk(K_RDY, 11'd1);
    step(10'd701, 10'd10, 1'b0);
    bus.dir_valid = 1'b0;
    chk(K_RDY, {10'd0, rdy_after});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bus.DrawX     = 10'd700;
    bus.DrawY     = 10'd0;
    bus.blank     = 1'b0;
    bus.sprite_x  = 10'd100;
    bus.sprite_y  = 10'd50;
    bus.dir_req   = 2'b00;
    bus.dir_valid = 1'b0;

    repeat (3) @(posedge vga_clk);
    #1;
    chk_reset_vals();
    step(10'd700, 10'd0, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // Latch position (100,50); heading down.
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    pix(10'd100, 10'd50, 1'b1, 11'd0,   1'b1, 2'b01);
    pix(10'd120, 10'd94, 1'b1, 11'd944, 1'b1, 2'b01);
    pix(10'd121, 10'd94, 1'b1, 11'd0,   1'b0, 2'b01);
    pix(10'd99,  10'd50, 1'b1, 11'd0,   1'b0, 2'b01);
    pix(10'd100, 10'd95, 1'b1, 11'd0,   1'b0, 2'b01);
    pix(10'd110, 10'd60, 1'b1, 11'd220, 1'b1, 2'b01);

    // Request right on the exact tick cycle: applied at the following tick.
    do_tick(1, 1'b1, 2'b11);
    idle(2);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b01);
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    chk(K_RDY, 11'd1);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b11);

    // Heading right: reversal (left) and same heading are both discarded.
    req(2'b10, 1'b1);
    req(2'b11, 1'b1);
    do_tick(1, 1'b0, 2'b00);
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b11);

    // Request up mid-frame: pending until the tick, then applied.
    req(2'b00, 1'b0);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b11);
    chk(K_RDY, 11'd0);
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    chk(K_RDY, 11'd1);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b00);
    req(2'b01, 1'b1);

    // Boundary held for 3 cycles: exactly one tick (7th tick overall).
    do_tick(3, 1'b0, 2'b00);
    idle(2);
    chk(K_ANIM, 11'd0);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b00);

    // 8th tick advances the animation frame.
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    chk(K_ANIM, 11'd1);
    pix(10'd100, 10'd50, 1'b1, 11'd945,  1'b1, 2'b00);
    pix(10'd120, 10'd94, 1'b1, 11'd1889, 1'b1, 2'b00);
    while (ntick < 16) do_tick(1, 1'b0, 2'b00);
    idle(2);
    chk(K_ANIM, 11'd0);
    pix(10'd100, 10'd50, 1'b1, 11'd0, 1'b1, 2'b00);

    // Right-edge clipping with px=630.
    bus.sprite_x = 10'd630;
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    pix(10'd639, 10'd60, 1'b1, 11'd219, 1'b1, 2'b00);
    pix(10'd629, 10'd60, 1'b1, 11'd0,   1'b0, 2'b00);
    pix(10'd5,   10'd60, 1'b1, 11'd0,   1'b0, 2'b00);
    pix(10'd635, 10'd60, 1'b0, 11'd0,   1'b0, 2'b00);
    idle(3);

    // Mid-frame reset with a pending request and a hit in flight.
    req(2'b10, 1'b0);
    step(10'd639, 10'd60, 1'b1);
    @(posedge vga_clk);
    #1;
    reset_n = 1'b0;
    chk_reset_vals();
    step(10'd700, 10'd0, 1'b0);
    step(10'd700, 10'd0, 1'b0);
    chk_reset_vals();
    reset_n = 1'b1;

    // First tick after reset applies nothing; position re-latched.
    do_tick(1, 1'b0, 2'b00);
    idle(2);
    chk(K_RDY, 11'd1);
    chk(K_ANIM, 11'd0);
    pix(10'd639, 10'd60, 1'b1, 11'd219, 1'b1, 2'b01);

    idle(4);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d checks left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
